uart_word_encoder: RTL and testbench

Converts 34-bit response words (2-bit code + 32-bit data) into the ASCII byte stream that the host console and the UART decoder understand, one byte per handshake, toward the UART transmitter. It is the return path of the UART-to-Wishbone bridge: bus responses come in, and hex text goes out to the tx serializer.

---
 rtl/uart_word_encoder.sv | 194 +++++++++++++++++++
 tb/tb_uart_word_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_word_encoder.sv
// rtl/uart_word_encoder.sv - response word to ASCII hex byte stream encoder
//
// Purpose:
//   Turns one 34-bit bus response word into ASCII text for the UART transmitter.
//   The text is a code letter, then eight hex digits of the data (most
//   significant nibble first), then TERM_CHAR. A write ack (code 2'b01) has no
//   data digits. The block emits one byte per o_stb/i_busy handshake.
//
// Ports:
//   i_clk    - system clock
//   i_reset  - synchronous, active-high reset
//   i_stb    - input word valid; it is accepted only while o_busy=0
//   i_word   - [33:32] response code, [31:0] response data
//   o_busy   - encoder occupied; upstream must hold off
//   o_stb    - o_byte valid
//   o_byte   - ASCII byte toward the transmitter
//   i_busy   - transmitter busy; a byte transfers when o_stb=1 and i_busy=0
//
// Build option:
//   UART_WORD_ENCODER_NEWLINE_EN - when defined, CR (0x0D) and LF (0x0A) follow
//   TERM_CHAR on every word.

module uart_word_encoder #(
    parameter logic [7:0] TERM_CHAR = 8'h45,
    parameter bit         LOWER_HEX = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [33:0] i_word,
    output logic        o_busy,
    output logic        o_stb,
    output logic [7:0]  o_byte,
    input  logic        i_busy
);

`ifdef UART_WORD_ENCODER_NEWLINE_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_HEX    = 3'd2,
        ST_TERM   = 3'd3,
        ST_CR     = 3'd4,
        ST_LF     = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_HEX    = 3'd2,
        ST_TERM   = 3'd3
    } state_t;
`endif

    localparam logic [1:0] CODE_WRITE_ACK = 2'b01;

    state_t      state_q;
    logic [31:0] shreg_q;   // data nibbles; the next digit is always in [31:28]
    logic [1:0]  code_q;
    logic [2:0]  cnt_q;     // digits already transferred in ST_HEX
    logic        stb_q;
    logic        busy_q;
    logic [7:0]  byte_q;

    logic        xfer;

    assign o_stb  = stb_q;
    assign o_busy = busy_q;
    assign o_byte = byte_q;

    // A byte leaves only when it is presented and the transmitter is free.
    assign xfer = stb_q & ~i_busy;

    function automatic logic [7:0] prefix_char(input logic [1:0] code);
        logic [7:0] c;
        case (code)
            2'b00:   c = 8'h52; // 'R'
            2'b01:   c = 8'h57; // 'W'
            2'b10:   c = 8'h41; // 'A'
            default: c = 8'h53; // 'S'
        endcase
        return c;
    endfunction

    // The letter offset is subtracted by 10 so that the nibble adds directly:
    // 0x57 + 10 = 'a', 0x37 + 10 = 'A'.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = 8'h30 + {4'h0, nib};
        end else if (LOWER_HEX) begin
            c = 8'h57 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shreg_q <= 32'h0;
            code_q  <= 2'b00;
            cnt_q   <= 3'd0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            case (state_q)
                // busy_q is always low here, so i_stb alone is an accept.
                ST_IDLE: begin
                    if (i_stb) begin
                        shreg_q <= i_word[31:0];
                        code_q  <= i_word[33:32];
                        byte_q  <= prefix_char(i_word[33:32]);
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREFIX;
                    end
                end

                ST_PREFIX: begin
                    if (xfer) begin
                        if (code_q == CODE_WRITE_ACK) begin
                            byte_q  <= TERM_CHAR;
                            state_q <= ST_TERM;
                        end else begin
                            byte_q  <= hex_char(shreg_q[31:28]);
                            cnt_q   <= 3'd0;
                            state_q <= ST_HEX;
                        end
                    end
                end

                // The byte for the following digit is prepared from [27:24]
                // because the shift lands on the same edge.
                ST_HEX: begin
                    if (xfer) begin
                        shreg_q <= {shreg_q[27:0], 4'h0};
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            byte_q  <= TERM_CHAR;
                            state_q <= ST_TERM;
                        end else begin
                            byte_q  <= hex_char(shreg_q[27:24]);
                        end
                    end
                end

`ifdef UART_WORD_ENCODER_NEWLINE_EN
                ST_TERM: begin
                    if (xfer) begin
                        byte_q  <= 8'h0D;
                        state_q <= ST_CR;
                    end
                end

                ST_CR: begin
                    if (xfer) begin
                        byte_q  <= 8'h0A;
                        state_q <= ST_LF;
                    end
                end

                ST_LF: begin
                    if (xfer) begin
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        byte_q  <= 8'h00;
                        state_q <= ST_IDLE;
                    end
                end
`else
                ST_TERM: begin
                    if (xfer) begin
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        byte_q  <= 8'h00;
                        state_q <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    byte_q  <= 8'h00;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_encoder.sv
// tb/tb_uart_word_encoder.sv - self-checking bench for uart_word_encoder

module tb_uart_word_encoder;

    logic        clk;
    logic        i_reset;
    logic        i_stb;
    logic [33:0] i_word;
    logic        o_busy;
    logic        o_stb;
    logic [7:0]  o_byte;
    logic        i_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_word_encoder dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_stb   (i_stb),
        .i_word  (i_word),
        .o_busy  (o_busy),
        .o_stb   (o_stb),
        .o_byte  (o_byte),
        .i_busy  (i_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] observed, input logic [33:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected text for one word, straight from the character rules.
    task automatic model(input logic [33:0] w);
        int d;
        exp_q.delete();
        case (w[33:32])
            2'b00:   exp_q.push_back(8'h52);
            2'b01:   exp_q.push_back(8'h57);
            2'b10:   exp_q.push_back(8'h41);
            default: exp_q.push_back(8'h53);
        endcase
        if (w[33:32] != 2'b01) begin
            for (int i = 7; i >= 0; i--) begin
                d = int'((w[31:0] >> (4 * i)) & 32'hF);
                exp_q.push_back(d < 10 ? 8'(48 + d) : 8'(97 + d - 10));
            end
        end
        exp_q.push_back(8'h45);
`ifdef UART_WORD_ENCODER_NEWLINE_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Called at a negedge with the encoder idle. mode: 0 no backpressure,
    // 1 random i_busy, 2 five-cycle stall on the 3rd byte, 3 i_busy toggling.
    task automatic run_word(input logic [33:0] w, input int mode, input bit inject);
        int         cyc;
        int         stall;
        bit         prev_stall;
        logic [7:0] prev_byte;
        model(w);
        got_q.delete();
        i_stb  = 1'b1;
        i_word = w;
        i_busy = 1'b0;
        @(negedge clk);
        i_stb  = 1'b0;
        i_word = {2'($urandom), 32'($urandom)};
        check("first_byte_stb", 34'(o_stb), 34'(1));
        check("busy_after_accept", 34'(o_busy), 34'(1));
        cyc = 0;
        stall = 0;
        prev_stall = 1'b0;
        prev_byte = 8'h00;
        while (o_stb === 1'b1 && cyc < 400) begin
            if (prev_stall) check("byte_hold", 34'(o_byte), 34'(prev_byte));
            case (mode)
                1: i_busy = 1'($urandom_range(0, 1));
                2: begin
                    if (got_q.size() == 2 && stall < 5) begin
                        i_busy = 1'b1;
                        stall++;
                        check("stall_third_byte", 34'(o_byte), 34'(exp_q[2]));
                    end else begin
                        i_busy = 1'b0;
                    end
                end
                3: i_busy = (cyc % 2 == 0);
                default: i_busy = 1'b0;
            endcase
            if (inject && cyc == 3) begin
                i_stb  = 1'b1;
                i_word = 34'h2_5555_aaaa;
            end else begin
                i_stb = 1'b0;
            end
            if (o_busy !== 1'b1) check("busy_while_stb", 34'(o_busy), 34'(1));
            if (!i_busy) got_q.push_back(o_byte);
            prev_stall = i_busy;
            prev_byte  = o_byte;
            @(negedge clk);
            cyc++;
        end
        i_stb  = 1'b0;
        i_busy = 1'b0;
        check("word_in_budget", 34'(cyc < 400), 34'(1));
        check("busy_low_at_end", 34'(o_busy), 34'(0));
        if (mode == 0) check("word_cycles", 34'(cyc), 34'(exp_q.size()));
        if (mode == 2) check("stall_cycles", 34'(stall), 34'(5));
        check("byte_count", 34'(got_q.size()), 34'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("byte_%0d", i), 34'(got_q[i]), 34'(exp_q[i]));
        end
    endtask

    initial begin
        logic [33:0] w;
        int          m;

        i_reset = 1'b1;
        i_stb   = 1'b0;
        i_word  = 34'h0;
        i_busy  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_stb", 34'(o_stb), 34'(0));
        check("reset_byte", 34'(o_byte), 34'(0));
        check("reset_busy", 34'(o_busy), 34'(0));
        i_reset = 1'b0;
        @(negedge clk);

        // Directed words
        run_word({2'b00, 32'hdeadbeef}, 0, 1'b0);
        run_word({2'b01, 32'h12345678}, 0, 1'b0);
        run_word({2'b10, 32'h0000000a}, 0, 1'b0);
        run_word({2'b11, 32'h00c0ffee}, 2, 1'b0);
        run_word({2'b00, 32'h13579bdf}, 0, 1'b1);
        @(negedge clk);
        check("injected_word_lost", 34'(o_stb), 34'(0));
        run_word({2'b01, 32'h00000000}, 3, 1'b0);

        // Reset in the middle of a word
        i_stb  = 1'b1;
        i_word = {2'b00, 32'h89abcdef};
        @(negedge clk);
        i_stb  = 1'b0;
        i_busy = 1'b0;
        repeat (4) @(negedge clk);
        check("fifth_byte_before_reset", 34'(o_byte), 34'(8'h62));
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check("midword_reset_stb", 34'(o_stb), 34'(0));
        check("midword_reset_byte", 34'(o_byte), 34'(0));
        check("midword_reset_busy", 34'(o_busy), 34'(0));
        @(negedge clk);
        check("no_bytes_after_reset", 34'(o_stb), 34'(0));
        run_word({2'b00, 32'h00000001}, 0, 1'b0);

        // Reset wins over a simultaneous strobe
        i_reset = 1'b1;
        i_stb   = 1'b1;
        i_word  = {2'b10, 32'hffffffff};
        @(negedge clk);
        i_reset = 1'b0;
        i_stb   = 1'b0;
        check("reset_prio_busy", 34'(o_busy), 34'(0));
        @(negedge clk);
        check("reset_prio_stb", 34'(o_stb), 34'(0));

        // Random words under random backpressure
        for (int n = 0; n < 16; n++) begin
            w = {2'($urandom), 32'($urandom)};
            m = $urandom_range(0, 3);
            if (m == 2 && w[33:32] == 2'b01) m = 1;
            run_word(w, m, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
